// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous flush and a selectable standard or first-word-fall-through read port.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       FIFO_full,
  output logic                       FIFO_empty,
  output logic                       FIFO_almost_full,
  output logic                       FIFO_almost_empty,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t DepthCnt = ptr_t'(DEPTH);
  localparam ptr_t AfCnt    = ptr_t'(AF_LEVEL);
  localparam ptr_t AeCnt    = ptr_t'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;

  // Flags are pure decodes of the registered occupancy.
  assign FIFO_full         = (count_q == DepthCnt);
  assign FIFO_empty        = (count_q == '0);
  assign FIFO_almost_full  = (count_q >= AfCnt);
  assign FIFO_almost_empty = (count_q <= AeCnt);
  assign fill_count        = count_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;

  assign wr_acc = wr_en && !FIFO_full && !flush;
  assign rd_acc = rd_en && !FIFO_empty && !flush;
  assign wr_idx = wr_ptr_q[ADDR_W-1:0];
  assign rd_idx = rd_ptr_q[ADDR_W-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // Error events are recorded even during flush; a same-cycle event beats clear_err.
    overflow_d  = (overflow_q && !clear_err) || (wr_en && FIFO_full);
    underflow_d = (underflow_q && !clear_err) || (rd_en && FIFO_empty);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ptr_t'(1);
        2'b01:   count_d = count_q - ptr_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = FIFO_empty ? '0 : mem[rd_idx];
    end else begin : g_std
      logic [WIDTH-1:0] data_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q <= '0;
        end else if (flush) begin
          data_q <= '0;
        end else if (rd_acc) begin
          data_q <= mem[rd_idx];
        end
      end

      assign data_out = data_q;
    end
  endgenerate

  // Pointer distance (MSB included) must always equal the occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count_q == ptr_t'(wr_ptr_q - rd_ptr_q));
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-read and an FWFT instance share one stimulus stream
// and are compared each cycle against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  data_in;
  logic              wr_en, rd_en, flush, clear_err;

  logic [WIDTH-1:0]  d0_dout, d1_dout;
  logic              d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_uf;
  logic              d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_uf;
  logic [3:0]        d0_cnt, d1_cnt;

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0))
    u_dut0 (
      .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .flush(flush), .clear_err(clear_err), .data_out(d0_dout), .FIFO_full(d0_full),
      .FIFO_empty(d0_empty), .FIFO_almost_full(d0_af), .FIFO_almost_empty(d0_ae),
      .fill_count(d0_cnt), .overflow(d0_ov), .underflow(d0_uf)
    );

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1))
    u_dut1 (
      .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .flush(flush), .clear_err(clear_err), .data_out(d1_dout), .FIFO_full(d1_full),
      .FIFO_empty(d1_empty), .FIFO_almost_full(d1_af), .FIFO_almost_empty(d1_ae),
      .fill_count(d1_cnt), .overflow(d1_ov), .underflow(d1_uf)
    );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the registered read word of the standard port.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout0;
  logic             m_ov, m_uf;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout0 = '0;
    m_ov    = 1'b0;
    m_uf    = 1'b0;
  endtask

  task automatic model_update();
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_ov = (m_ov && !clear_err) || (wr_en && was_full);
    m_uf = (m_uf && !clear_err) || (rd_en && was_empty);
    if (flush) begin
      mq.delete();
      m_dout0 = '0;
    end else begin
      if (rd_en && !was_empty) m_dout0 = mq.pop_front();
      if (wr_en && !was_full) mq.push_back(data_in);
    end
  endtask

  task automatic check_outputs();
    int n;
    logic [WIDTH-1:0] head;
    n    = mq.size();
    head = (n > 0) ? mq[0] : '0;
    chk("dout_std",  32'(d0_dout), 32'(m_dout0));
    chk("dout_fwft", 32'(d1_dout), 32'(head));
    chk("count0",    32'(d0_cnt),  32'(n));
    chk("count1",    32'(d1_cnt),  32'(n));
    chk("full0",     32'(d0_full), 32'(n == DEPTH));
    chk("empty0",    32'(d0_empty), 32'(n == 0));
    chk("afull0",    32'(d0_af),   32'(n >= AF));
    chk("aempty0",   32'(d0_ae),   32'(n <= AE));
    chk("full1",     32'(d1_full), 32'(n == DEPTH));
    chk("empty1",    32'(d1_empty), 32'(n == 0));
    chk("ovf0",      32'(d0_ov),   32'(m_ov));
    chk("udf0",      32'(d0_uf),   32'(m_uf));
    chk("ovf1",      32'(d1_ov),   32'(m_ov));
    chk("udf1",      32'(d1_uf),   32'(m_uf));
  endtask

  // Drive one cycle of inputs (called #1 after an edge), clock it, then check.
  task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [15:0] d);
    wr_en     = w;
    rd_en     = r;
    flush     = f;
    clear_err = c;
    data_in   = d;
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_err = 1'b0; data_in = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // Fill 1..8: almost-full at 6, full after the 8th edge.
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0, 16'(i));
      if (i == 6) chk("af_at_6", 32'(d0_af), 32'd1);
    end
    chk("full_after_8", 32'(d0_full), 32'd1);

    // Write while full: rejected, overflow set, then cleared.
    step(1, 0, 0, 0, 16'd9);
    chk("ovf_set", 32'(d0_ov), 32'd1);
    chk("cnt_stays_8", 32'(d0_cnt), 32'd8);
    step(0, 0, 0, 1, 16'd0);
    chk("ovf_cleared", 32'(d0_ov), 32'd0);

    // Drain: standard port shows 1..8, one word per read.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 16'd0);
      chk("drain_order", 32'(d0_dout), 32'(i));
    end
    chk("empty_after_drain", 32'(d0_empty), 32'd1);

    // Read while empty: underflow; data_out holds; clear loses to a same-cycle event.
    step(0, 1, 0, 0, 16'd0);
    chk("udf_set", 32'(d0_uf), 32'd1);
    chk("dout_holds", 32'(d0_dout), 32'd8);
    step(0, 1, 0, 1, 16'd0);
    chk("udf_sticky_vs_clear", 32'(d0_uf), 32'd1);
    step(0, 0, 0, 1, 16'd0);

    // Fill 4, then 20 simultaneous read/write cycles: count stays 4, pointers wrap.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'(100 + i));
    for (int i = 10; i < 30; i++) begin
      step(1, 1, 0, 0, 16'(i));
      chk("steady_cnt", 32'(d0_cnt), 32'd4);
    end

    // Flush, then FWFT fall-through of a single word, then flush with a concurrent write.
    step(0, 0, 1, 0, 16'd0);
    step(1, 0, 0, 0, 16'hA5A5);
    chk("fwft_fallthrough", 32'(d1_dout), 32'hA5A5);
    step(1, 0, 1, 0, 16'h1234);
    chk("flush_cnt", 32'(d1_cnt), 32'd0);
    chk("flush_dout", 32'(d1_dout), 32'd0);

    // Asynchronous reset mid-stream with five words held.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'(200 + i));
    chk("cnt_before_reset", 32'(d0_cnt), 32'd5);
    step(1, 1, 0, 0, 16'h0BAD);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // Randomised traffic with phase-dependent biases to visit full and empty often.
    for (int blk = 0; blk < 10; blk++) begin
      int wp, rp;
      wp = (blk % 2 == 0) ? 75 : 30;
      rp = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
             16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
